// File: rtl/useq_stack.sv
// rtl/useq_stack.sv - microprogram sequencer with dispatch, conditional branch and call/return stack
module useq_stack #(
    parameter int AW        = 8,
    parameter int SD        = 4,
    parameter int FW        = 8,
    parameter int OPW       = 4,
    parameter int MAP_BASE  = 16,
    parameter int MAP_SHIFT = 2,
    localparam int CSW      = (FW > 1) ? $clog2(FW) : 1,
    localparam int SPW      = $clog2(SD + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_valid,
    input  logic [2:0]       i_seq_op,
    input  logic [AW-1:0]    i_target,
    input  logic [CSW-1:0]   i_cond_sel,
    input  logic             i_cond_pol,
    input  logic [OPW-1:0]   i_opcode,
    input  logic [FW-1:0]    i_flags,
    output logic [AW-1:0]    o_uaddr,
    output logic [SPW-1:0]   o_sp,
    output logic             o_err_ovf,
    output logic             o_err_unf
);

    // Wide enough to hold the un-truncated dispatch sum before wrapping to AW.
    localparam int DW = (AW > OPW + MAP_SHIFT) ? AW + 1 : OPW + MAP_SHIFT + 1;

    typedef enum logic [2:0] {
        OP_NEXT     = 3'b000,
        OP_DISPATCH = 3'b001,
        OP_JUMP     = 3'b010,
        OP_CJUMP    = 3'b011,
        OP_CALL     = 3'b100,
        OP_RET      = 3'b101,
        OP_HOLD     = 3'b110,
        OP_FETCH    = 3'b111
    } seq_op_e;

    logic [AW-1:0]  r_uaddr;
    logic [SPW-1:0] r_sp;
    logic           r_err_ovf;
    logic           r_err_unf;
    logic [AW-1:0]  r_stack [SD];

    seq_op_e        w_op;
    logic [AW-1:0]  w_inc;
    logic [DW-1:0]  w_disp_full;
    logic [AW-1:0]  w_disp;
    logic           w_full;
    logic           w_empty;
    logic           w_cond_ok;
    logic [AW-1:0]  w_top;
    logic           w_update;
    logic [AW-1:0]  w_nxt_uaddr;
    logic [SPW-1:0] w_nxt_sp;
    logic           w_push;
    logic           w_set_ovf;
    logic           w_set_unf;

    assign w_op        = seq_op_e'(i_seq_op);
    assign w_inc       = r_uaddr + AW'(1);
    assign w_disp_full = DW'(MAP_BASE) + (DW'(i_opcode) << MAP_SHIFT);
    assign w_disp      = w_disp_full[AW-1:0];
    assign w_full      = (r_sp == SPW'(SD));
    assign w_empty     = (r_sp == '0);
    assign w_update    = i_run & i_valid;

    // Flag test for CJUMP; a select beyond the flag vector never branches.
    always_comb begin
        w_cond_ok = 1'b0;
        if (int'(i_cond_sel) < FW) begin
            w_cond_ok = (i_flags[i_cond_sel] == i_cond_pol);
        end
    end

    // Top-of-stack read: the entry just below the stack pointer.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < SD; i++) begin
            if (int'(r_sp) == i + 1) begin
                w_top = r_stack[i];
            end
        end
    end

    // Next micro-address, stack pointer and error events for the current op.
    always_comb begin
        w_nxt_uaddr = r_uaddr;
        w_nxt_sp    = r_sp;
        w_push      = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        case (w_op)
            OP_NEXT:     w_nxt_uaddr = w_inc;
            OP_DISPATCH: w_nxt_uaddr = w_disp;
            OP_JUMP:     w_nxt_uaddr = i_target;
            OP_CJUMP:    w_nxt_uaddr = w_cond_ok ? i_target : w_inc;
            OP_CALL: begin
                if (w_full) begin
                    // Overflowing call falls through so the microprogram keeps moving.
                    w_set_ovf   = 1'b1;
                    w_nxt_uaddr = w_inc;
                end else begin
                    w_push      = 1'b1;
                    w_nxt_sp    = r_sp + SPW'(1);
                    w_nxt_uaddr = i_target;
                end
            end
            OP_RET: begin
                if (w_empty) begin
                    // Underflowing return restarts at the fetch routine.
                    w_set_unf   = 1'b1;
                    w_nxt_uaddr = '0;
                end else begin
                    w_nxt_sp    = r_sp - SPW'(1);
                    w_nxt_uaddr = w_top;
                end
            end
            OP_HOLD:     w_nxt_uaddr = r_uaddr;
            OP_FETCH:    w_nxt_uaddr = '0;
            default:     w_nxt_uaddr = r_uaddr;
        endcase
    end

    // Sequencer state: reset clears address, depth and sticky errors; otherwise advance when enabled.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_uaddr   <= '0;
            r_sp      <= '0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else if (w_update) begin
            r_uaddr <= w_nxt_uaddr;
            r_sp    <= w_nxt_sp;
            if (w_set_ovf) begin
                r_err_ovf <= 1'b1;
            end
            if (w_set_unf) begin
                r_err_unf <= 1'b1;
            end
        end
    end

    // Return-address storage: a push writes the slot at the current depth; contents are not reset.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_update && w_push) begin
            for (int i = 0; i < SD; i++) begin
                if (int'(r_sp) == i) begin
                    r_stack[i] <= w_inc;
                end
            end
        end
    end

    assign o_uaddr   = r_uaddr;
    assign o_sp      = r_sp;
    assign o_err_ovf = r_err_ovf;
    assign o_err_unf = r_err_unf;

endmodule

// File: tb/tb_useq_stack.sv
// tb/tb_useq_stack.sv - scoreboard bench for useq_stack with directed vectors
module tb_useq_stack;

    localparam logic [2:0] NX = 3'b000;
    localparam logic [2:0] DS = 3'b001;
    localparam logic [2:0] JP = 3'b010;
    localparam logic [2:0] CJ = 3'b011;
    localparam logic [2:0] CL = 3'b100;
    localparam logic [2:0] RT = 3'b101;
    localparam logic [2:0] HD = 3'b110;
    localparam logic [2:0] FT = 3'b111;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       valid;
    logic [2:0] seq_op;
    logic [7:0] target;
    logic [2:0] cond_sel;
    logic       cond_pol;
    logic [3:0] opcode;
    logic [7:0] flags;
    logic [7:0] uaddr;
    logic [2:0] sp;
    logic       err_ovf;
    logic       err_unf;

    typedef struct {
        logic [7:0] ua;
        logic [2:0] sp;
        logic       ovf;
        logic       unf;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    useq_stack #(
        .AW(8), .SD(4), .FW(8), .OPW(4), .MAP_BASE(16), .MAP_SHIFT(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_valid(valid),
        .i_seq_op(seq_op), .i_target(target), .i_cond_sel(cond_sel),
        .i_cond_pol(cond_pol), .i_opcode(opcode), .i_flags(flags),
        .o_uaddr(uaddr), .o_sp(sp), .o_err_ovf(err_ovf), .o_err_unf(err_unf)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge and queue the hand-computed result.
    task automatic step(input logic r, input logic rn, input logic v, input logic [2:0] op,
                        input logic [7:0] tg, input logic [2:0] cs, input logic cp,
                        input logic [3:0] oc, input logic [7:0] fl,
                        input logic [7:0] e_ua, input logic [2:0] e_sp,
                        input logic e_ovf, input logic e_unf, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; run = rn; valid = v; seq_op = op; target = tg;
        cond_sel = cs; cond_pol = cp; opcode = oc; flags = fl;
        e.ua = e_ua; e.sp = e_sp; e.ovf = e_ovf; e.unf = e_unf; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: after every rising edge, compare DUT state against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (uaddr !== e.ua || sp !== e.sp || err_ovf !== e.ovf || err_unf !== e.unf) begin
                    n_bad++;
                    $display("FAIL %s: got uaddr=%02h sp=%0d ovf=%b unf=%b, want uaddr=%02h sp=%0d ovf=%b unf=%b",
                             e.name, uaddr, sp, err_ovf, err_unf, e.ua, e.sp, e.ovf, e.unf);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; run = 1'b0; valid = 1'b0; seq_op = NX; target = 8'h00;
        cond_sel = 3'd0; cond_pol = 1'b0; opcode = 4'd0; flags = 8'h00;

        //    rst  run  val op  target cs    cp    oc    flags  uaddr  sp    ovf   unf
        step(1'b0, 1'b1, 1'b1, NX, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "reset");
        step(1'b1, 1'b1, 1'b1, NX, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0, "next1");
        step(1'b1, 1'b1, 1'b1, NX, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'h02, 3'd0, 1'b0, 1'b0, "next2");
        step(1'b1, 1'b1, 1'b1, NX, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'h03, 3'd0, 1'b0, 1'b0, "next3");
        step(1'b0, 1'b1, 1'b1, NX, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "reset_mid");
        // Wrap of NEXT and of the pushed return address.
        step(1'b1, 1'b1, 1'b1, JP, 8'hFF, 3'd0, 1'b0, 4'd0, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, "jump_ff");
        step(1'b1, 1'b1, 1'b1, NX, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "next_wrap");
        step(1'b1, 1'b1, 1'b1, JP, 8'hFF, 3'd0, 1'b0, 4'd0, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, "jump_ff2");
        step(1'b1, 1'b1, 1'b1, CL, 8'h40, 3'd0, 1'b0, 4'd0, 8'h00, 8'h40, 3'd1, 1'b0, 1'b0, "call_wrap");
        step(1'b1, 1'b1, 1'b1, RT, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "ret_wrap");
        // Dispatch, jump, hold via valid=0 and run=0.
        step(1'b1, 1'b1, 1'b1, DS, 8'h00, 3'd0, 1'b0, 4'd5, 8'h00, 8'd36, 3'd0, 1'b0, 1'b0, "dispatch5");
        step(1'b1, 1'b1, 1'b1, DS, 8'h00, 3'd0, 1'b0, 4'd15, 8'h00, 8'd76, 3'd0, 1'b0, 1'b0, "dispatch15");
        step(1'b1, 1'b1, 1'b1, JP, 8'h80, 3'd0, 1'b0, 4'd0, 8'h00, 8'h80, 3'd0, 1'b0, 1'b0, "jump80");
        step(1'b1, 1'b1, 1'b0, NX, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'h80, 3'd0, 1'b0, 1'b0, "invalid1");
        step(1'b1, 1'b1, 1'b0, CL, 8'h22, 3'd0, 1'b0, 4'd0, 8'h00, 8'h80, 3'd0, 1'b0, 1'b0, "invalid2");
        step(1'b1, 1'b0, 1'b1, NX, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'h80, 3'd0, 1'b0, 1'b0, "run_off");
        step(1'b1, 1'b1, 1'b1, HD, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'h80, 3'd0, 1'b0, 1'b0, "hold");
        step(1'b1, 1'b1, 1'b1, FT, 8'h33, 3'd0, 1'b0, 4'd0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "fetch");
        // Conditional branches on flags=0x04.
        step(1'b1, 1'b1, 1'b1, JP, 8'd10, 3'd0, 1'b0, 4'd0, 8'h04, 8'd10, 3'd0, 1'b0, 1'b0, "jump10");
        step(1'b1, 1'b1, 1'b1, CJ, 8'd50, 3'd2, 1'b1, 4'd0, 8'h04, 8'd50, 3'd0, 1'b0, 1'b0, "cj_taken");
        step(1'b1, 1'b1, 1'b1, CJ, 8'd90, 3'd2, 1'b0, 4'd0, 8'h04, 8'd51, 3'd0, 1'b0, 1'b0, "cj_pol0");
        step(1'b1, 1'b1, 1'b1, CJ, 8'd90, 3'd3, 1'b1, 4'd0, 8'h04, 8'd52, 3'd0, 1'b0, 1'b0, "cj_sel3");
        step(1'b1, 1'b1, 1'b1, CJ, 8'd99, 3'd3, 1'b0, 4'd0, 8'h04, 8'd99, 3'd0, 1'b0, 1'b0, "cj_sel3_pol0");
        // Nested calls, overflow, unwinding.
        step(1'b1, 1'b1, 1'b1, JP, 8'd10, 3'd0, 1'b0, 4'd0, 8'h00, 8'd10, 3'd0, 1'b0, 1'b0, "jump10b");
        step(1'b1, 1'b1, 1'b1, CL, 8'd20, 3'd0, 1'b0, 4'd0, 8'h00, 8'd20, 3'd1, 1'b0, 1'b0, "call20");
        step(1'b1, 1'b1, 1'b1, CL, 8'd30, 3'd0, 1'b0, 4'd0, 8'h00, 8'd30, 3'd2, 1'b0, 1'b0, "call30");
        step(1'b1, 1'b1, 1'b1, CL, 8'd40, 3'd0, 1'b0, 4'd0, 8'h00, 8'd40, 3'd3, 1'b0, 1'b0, "call40");
        step(1'b1, 1'b1, 1'b1, CL, 8'd50, 3'd0, 1'b0, 4'd0, 8'h00, 8'd50, 3'd4, 1'b0, 1'b0, "call50");
        step(1'b1, 1'b1, 1'b1, CL, 8'd60, 3'd0, 1'b0, 4'd0, 8'h00, 8'd51, 3'd4, 1'b1, 1'b0, "call_ovf");
        step(1'b1, 1'b1, 1'b1, RT, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'd41, 3'd3, 1'b1, 1'b0, "ret41");
        step(1'b1, 1'b1, 1'b1, RT, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'd31, 3'd2, 1'b1, 1'b0, "ret31");
        step(1'b1, 1'b1, 1'b1, RT, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'd21, 3'd1, 1'b1, 1'b0, "ret21");
        step(1'b1, 1'b1, 1'b1, RT, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'd11, 3'd0, 1'b1, 1'b0, "ret11");
        // Underflow, sticky errors, reset clears them.
        step(1'b1, 1'b1, 1'b1, RT, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'd0, 3'd0, 1'b1, 1'b1, "ret_unf");
        step(1'b1, 1'b1, 1'b1, NX, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'd1, 3'd0, 1'b1, 1'b1, "next_sticky");
        step(1'b1, 1'b1, 1'b1, CL, 8'd70, 3'd0, 1'b0, 4'd0, 8'h00, 8'd70, 3'd1, 1'b1, 1'b1, "call_after_err");
        step(1'b1, 1'b1, 1'b1, RT, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'd2, 3'd0, 1'b1, 1'b1, "ret_after_err");
        step(1'b0, 1'b0, 1'b0, NX, 8'h00, 3'd0, 1'b0, 4'd0, 8'h00, 8'd0, 3'd0, 1'b0, 1'b0, "reset_clear");

        // Let the monitor drain the last expectations, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
